// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler
// ------------------
// Occupancy and issue controller for a bank of reservation-station entries.
// Dispatch is granted the lowest-index free entry. One ready entry at a time
// is presented to a single execution unit through a valid/ready handshake.
//
// Selection policy:
//   default             : round-robin, starting at the entry after the last issue
//   RS_OLDEST_FIRST_EN  : oldest ready entry first, tracked by an age matrix
//
// Ports:
//   clk          in   clock, all state updates on rising edge
//   rst          in   synchronous active-high reset (priority over flush)
//   flush        in   discard all entries
//   alloc_req    in   dispatch requests one entry this cycle
//   alloc_grant  out  request accepted this cycle (combinational)
//   alloc_idx    out  index of the granted entry
//   write_alloc  out  one-hot write-allocate strobe to the entries
//   entry_ready  in   per-entry ready (both operands captured)
//   issue_valid  out  an entry is presented for issue
//   issue_ready  in   execution unit accepts the presented entry
//   issue_idx    out  index of the presented entry
//   read_enable  out  one-hot read-enable of the presented entry, 0 when idle
//   occupancy    out  number of busy entries
//   full         out  occupancy == NUM_ENTRIES
//   empty        out  occupancy == 0

module rs_issue_scheduler #(
    parameter int NUM_ENTRIES = 4,
    parameter int IDX_W       = $clog2(NUM_ENTRIES),
    parameter int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   alloc_req,
    output logic                   alloc_grant,
    output logic [IDX_W-1:0]       alloc_idx,
    output logic [NUM_ENTRIES-1:0] write_alloc,
    input  logic [NUM_ENTRIES-1:0] entry_ready,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [IDX_W-1:0]       issue_idx,
    output logic [NUM_ENTRIES-1:0] read_enable,
    output logic [CNT_W-1:0]       occupancy,
    output logic                   full,
    output logic                   empty
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t                 state;
    logic [NUM_ENTRIES-1:0] busy;
    logic [CNT_W-1:0]       occ;
    logic [IDX_W-1:0]       sel_idx;

    logic [IDX_W-1:0]       free_idx;
    logic                   free_found;
    logic [NUM_ENTRIES-1:0] candidates;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_found;
    logic                   handshake;
    logic [NUM_ENTRIES-1:0] clear_mask;

    assign occupancy = occ;
    assign full      = (occ == CNT_W'(NUM_ENTRIES));
    assign empty     = (occ == '0);
    assign issue_idx = sel_idx;

    // Flush is handled by the priority branch of the state register, so a
    // handshake coinciding with flush never reaches busy/occupancy.
    assign handshake  = (state == PRESENT) && issue_ready;
    assign clear_mask = handshake ? (NUM_ENTRIES'(1) << sel_idx) : '0;

    // Lowest-index free entry. The descending loop leaves the smallest hit.
    always_comb begin
        // NOTE: every variable written here gets a default first, otherwise
        // paths that skip the assignment infer a latch.
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    // Grant is also held off while rst is high so no strobe reaches the
    // entries during reset.
    assign alloc_grant = alloc_req && !full && !flush && !rst && free_found;
    assign alloc_idx   = free_idx;
    assign write_alloc = alloc_grant ? (NUM_ENTRIES'(1) << free_idx) : '0;

    // An entry being written this cycle is not yet a legal issue candidate.
    assign candidates = busy & entry_ready & ~write_alloc;

`ifdef RS_OLDEST_FIRST_EN
    // age[i][j] = 1 : entry i was allocated before entry j.
    logic [NUM_ENTRIES-1:0] age [NUM_ENTRIES];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) age[i] <= '0;
        end else if (alloc_grant) begin
            // New entry becomes younger than everything else: its row is
            // cleared and its column set. Stale bits for free entries are
            // harmless because only busy candidates are compared.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (IDX_W'(i) == free_idx) age[i] <= '0;
                else                       age[i][free_idx] <= 1'b1;
            end
        end
    end

    // Oldest ready first: the candidate that no other candidate is older than.
    always_comb begin
        logic has_older;
        pick_idx   = '0;
        pick_found = 1'b0;
        has_older  = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            has_older = 1'b0;
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (j != i && candidates[j] && age[j][i]) has_older = 1'b1;
            end
            if (candidates[i] && !has_older && !pick_found) begin
                pick_idx   = IDX_W'(i);
                pick_found = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr;

    // rr_ptr survives flush so fairness carries across a pipeline restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (!flush && handshake) begin
            rr_ptr <= (sel_idx == IDX_W'(NUM_ENTRIES - 1)) ? '0 : sel_idx + IDX_W'(1);
        end
    end

    // First candidate at or after rr_ptr, wrapping modulo NUM_ENTRIES.
    always_comb begin
        int p;
        pick_idx   = '0;
        pick_found = 1'b0;
        p          = 0;
        for (int off = 0; off < NUM_ENTRIES; off++) begin
            p = (int'(rr_ptr) + off) % NUM_ENTRIES;
            if (!pick_found && candidates[p]) begin
                pick_idx   = IDX_W'(p);
                pick_found = 1'b1;
            end
        end
    end
`endif

    // Busy map, occupancy and issue FSM. issue_valid/read_enable are
    // registered alongside the state so they are glitch-free to the EU.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // right-hand side sees the pre-edge values regardless of order.
        if (rst) begin
            busy        <= '0;
            occ         <= '0;
            state       <= IDLE;
            sel_idx     <= '0;
            issue_valid <= 1'b0;
            read_enable <= '0;
        end else if (flush) begin
            busy        <= '0;
            occ         <= '0;
            state       <= IDLE;
            issue_valid <= 1'b0;
            read_enable <= '0;
        end else begin
            // A grant never targets a busy entry, so set and clear bits
            // cannot collide.
            busy <= (busy | write_alloc) & ~clear_mask;

            case ({alloc_grant, handshake})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase

            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state       <= PRESENT;
                        sel_idx     <= pick_idx;
                        issue_valid <= 1'b1;
                        read_enable <= NUM_ENTRIES'(1) << pick_idx;
                    end
                end
                PRESENT: begin
                    // Selection is frozen here; entry_ready is not looked at.
                    if (issue_ready) begin
                        state       <= IDLE;
                        issue_valid <= 1'b0;
                        read_enable <= '0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    issue_valid <= 1'b0;
                    read_enable <= '0;
                end
            endcase
        end
    end

endmodule
